// File: rtl/soduku_board_checker.sv
// Sequential Sudoku board checker: latches a board, then scores one row/column/square
// per cycle through a one-stage pipeline and publishes the totals when it finishes.
module soduku_board_checker #(
    parameter int BOX_SIZE  = 3,
    parameter int DIGIT_W   = 4,
    localparam int GRID_SIZE = BOX_SIZE * BOX_SIZE,
    localparam int NUM_CELLS = GRID_SIZE * GRID_SIZE,
    localparam int NUM_UNITS = 3 * GRID_SIZE,
    localparam int COUNT_W   = $clog2(NUM_UNITS + 1),
    localparam int UNIT_W    = $clog2(NUM_UNITS)
) (
    input  logic                         clk_in,
    input  logic                         reset_in,
    input  logic                         start_in,
    input  logic [DIGIT_W*NUM_CELLS-1:0] board_in,
    output logic                         busy_out,
    output logic                         done_out,
    output logic                         valid_out,
    output logic                         complete_out,
    output logic [COUNT_W-1:0]           error_count_out,
    output logic [UNIT_W-1:0]            first_error_out
);

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    localparam logic [COUNT_W-1:0] LAST_STEP = COUNT_W'(NUM_UNITS);
    localparam logic [COUNT_W-1:0] ROW_UNITS = COUNT_W'(GRID_SIZE);

    // Flat cell index of member m of unit u (rows, then columns, then squares).
    function automatic int cell_of(input int u, input int m);
        int s;
        if (u < GRID_SIZE) begin
            return u * GRID_SIZE + m;
        end else if (u < 2 * GRID_SIZE) begin
            return m * GRID_SIZE + (u - GRID_SIZE);
        end else begin
            s = u - 2 * GRID_SIZE;
            return ((s / BOX_SIZE) * BOX_SIZE + m / BOX_SIZE) * GRID_SIZE
                 + (s % BOX_SIZE) * BOX_SIZE + m % BOX_SIZE;
        end
    endfunction

    state_t                       state_reg, state_next;
    logic [DIGIT_W*NUM_CELLS-1:0] board_reg;
    logic [COUNT_W-1:0]           unit_reg;

    logic                         pipe_valid_reg, pipe_fail_reg, pipe_zero_reg;
    logic [UNIT_W-1:0]            pipe_unit_reg;

    logic [COUNT_W-1:0]           acc_count_reg, acc_count_next;
    logic [UNIT_W-1:0]            acc_first_reg, acc_first_next;
    logic                         acc_any_reg, acc_any_next;
    logic                         acc_complete_reg, acc_complete_next;

    logic                         res_valid_reg, res_complete_reg;
    logic [COUNT_W-1:0]           res_count_reg;
    logic [UNIT_W-1:0]            res_first_reg;

    logic [DIGIT_W-1:0]           cells     [NUM_CELLS];
    logic [DIGIT_W-1:0]           unit_vals [NUM_UNITS][GRID_SIZE];
    logic [DIGIT_W-1:0]           cur_vals  [GRID_SIZE];
    logic [2**DIGIT_W-1:0]        seen;
    logic                         cur_fail, cur_zero, pipe_hit;

    generate
        for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
            assign cells[gi] = board_reg[DIGIT_W*(NUM_CELLS-gi)-1 -: DIGIT_W];
        end
        for (genvar gu = 0; gu < NUM_UNITS; gu++) begin : g_unit
            for (genvar gm = 0; gm < GRID_SIZE; gm++) begin : g_member
                localparam int CI = cell_of(gu, gm);
                assign unit_vals[gu][gm] = cells[CI];
            end
        end
    endgenerate

    always_comb begin
        cur_vals = unit_vals[0];
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (unit_reg == COUNT_W'(u)) cur_vals = unit_vals[u];
        end
    end

    // Presence bitmap catches repeats; zeros are empty cells, not digits.
    always_comb begin
        seen     = '0;
        cur_fail = 1'b0;
        cur_zero = 1'b0;
        for (int i = 0; i < GRID_SIZE; i++) begin
            if (cur_vals[i] == '0) begin
                cur_zero = 1'b1;
            end else begin
                if (cur_vals[i] > DIGIT_W'(GRID_SIZE)) cur_fail = 1'b1;
                if (seen[cur_vals[i]]) cur_fail = 1'b1;
                seen[cur_vals[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        pipe_hit          = pipe_valid_reg & pipe_fail_reg;
        acc_count_next    = acc_count_reg + COUNT_W'(pipe_hit);
        acc_first_next    = (pipe_hit && !acc_any_reg) ? pipe_unit_reg : acc_first_reg;
        acc_any_next      = acc_any_reg | pipe_hit;
        acc_complete_next = acc_complete_reg & ~(pipe_valid_reg & pipe_zero_reg);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // CHECK runs one extra step so the last unit can drain out of the pipeline.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_in) state_next = CHECK;
            CHECK:   if (unit_reg == LAST_STEP) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_out = (state_reg != IDLE);
        done_out = (state_reg == DONE);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            board_reg        <= '0;
            unit_reg         <= '0;
            pipe_valid_reg   <= 1'b0;
            pipe_fail_reg    <= 1'b0;
            pipe_zero_reg    <= 1'b0;
            pipe_unit_reg    <= '0;
            acc_count_reg    <= '0;
            acc_first_reg    <= '0;
            acc_any_reg      <= 1'b0;
            acc_complete_reg <= 1'b0;
            res_valid_reg    <= 1'b0;
            res_complete_reg <= 1'b0;
            res_count_reg    <= '0;
            res_first_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_in) begin
                        board_reg        <= board_in;
                        unit_reg         <= '0;
                        pipe_valid_reg   <= 1'b0;
                        acc_count_reg    <= '0;
                        acc_first_reg    <= '0;
                        acc_any_reg      <= 1'b0;
                        acc_complete_reg <= 1'b1;
                    end
                end
                CHECK: begin
                    pipe_valid_reg   <= (unit_reg < LAST_STEP);
                    pipe_fail_reg    <= cur_fail;
                    pipe_zero_reg    <= cur_zero & (unit_reg < ROW_UNITS);
                    pipe_unit_reg    <= unit_reg[UNIT_W-1:0];
                    unit_reg         <= unit_reg + 1'b1;
                    acc_count_reg    <= acc_count_next;
                    acc_first_reg    <= acc_first_next;
                    acc_any_reg      <= acc_any_next;
                    acc_complete_reg <= acc_complete_next;
                    if (unit_reg == LAST_STEP) begin
                        res_valid_reg    <= ~acc_any_next;
                        res_complete_reg <= acc_complete_next;
                        res_count_reg    <= acc_count_next;
                        res_first_reg    <= acc_first_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid_out       = res_valid_reg;
    assign complete_out    = res_complete_reg;
    assign error_count_out = res_count_reg;
    assign first_error_out = res_first_reg;

endmodule

// File: doc/soduku_board_checker.md
SODUKU_BOARD_CHECKER -- requirements
Module: soduku_board_checker

Interface
REQ-001 Parameter BOX_SIZE, default 3: side of one square; GRID_SIZE = BOX_SIZE*BOX_SIZE (derived, not overridable).
REQ-002 Parameter DIGIT_W, default 4: bits per cell; SHALL satisfy 2**DIGIT_W > GRID_SIZE.
REQ-003 clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 reset_in  input  1  synchronous, active-high reset.
REQ-005 start_in  input  1  request a check of board_in; sampled only in IDLE.
REQ-006 board_in  input  DIGIT_W*GRID_SIZE*GRID_SIZE  flattened board; cell (r,c) at bits [DIGIT_W*(GRID_SIZE*GRID_SIZE - r*GRID_SIZE - c)-1 -: DIGIT_W], so row 0 col 0 is the MSBs; 0 = empty.
REQ-007 busy_out  output  1  high while a check is in progress.
REQ-008 done_out  output  1  one-cycle pulse when results become valid.
REQ-009 valid_out  output  1  no duplicate and no out-of-range digit found.
REQ-010 complete_out  output  1  no cell equals 0.
REQ-011 error_count_out  output  clog2(3*GRID_SIZE+1)  number of failing units.
REQ-012 first_error_out  output  clog2(3*GRID_SIZE)  index of the lowest failing unit; 0 when none fail.

Function
REQ-013 Units are indexed 0..3*GRID_SIZE-1: rows 0..G-1, columns G..2G-1, squares 2G..3G-1 (G = GRID_SIZE).
REQ-014 Square s, member i SHALL be cell row (s/BOX_SIZE)*BOX_SIZE + i/BOX_SIZE, col (s%BOX_SIZE)*BOX_SIZE + i%BOX_SIZE.
REQ-015 FSM states: IDLE, CHECK, DONE; there SHALL be no other reachable state.
REQ-016 IDLE: when start_in=1, latch board_in into an internal register, clear result accumulators, set unit counter to 0, go to CHECK; otherwise remain.
REQ-017 CHECK: evaluate exactly one unit per cycle, in index order, from the latched board only; after unit 3G-1, go to DONE.
REQ-018 A unit fails if any nonzero digit appears twice in it, or if any digit > GRID_SIZE is present in it.
REQ-019 On each failing unit: increment error_count; if it is the first failure, record its index in first_error.
REQ-020 complete SHALL be cleared if any cell of any row unit is 0.
REQ-021 DONE: assert done_out for exactly one cycle, then return to IDLE; results SHALL hold until the next accepted start.
REQ-022 Latency: with start_in accepted on edge T, done_out SHALL be high in the cycle after edge T+3G+1 (28 cycles for G=9, 13 for G=4).
REQ-023 busy_out SHALL be high in CHECK and DONE, and low in IDLE.
REQ-024 start_in while busy SHALL be ignored. board_in changes after acceptance SHALL NOT affect the result.
REQ-025 Results SHALL be undefined to the user while busy_out=1; valid_out, complete_out, error_count_out and first_error_out SHALL update only at DONE entry.
REQ-026 Every unit SHALL be checked even after a failure; there is no early termination.

Reset
REQ-027 reset_in=1 on any edge, including mid-CHECK, SHALL force IDLE and abort any check in progress.
REQ-028 Outputs in and immediately after reset: busy_out=0, done_out=0, valid_out=0, complete_out=0, error_count_out=0, first_error_out=0; the internal board register SHALL be cleared.
REQ-029 start_in asserted in the same cycle as reset_in SHALL be ignored.

Verification
REQ-030 BOX_SIZE=3, solved board with row 0 = 2 5 4 8 1 3 6 9 7, start pulse -> done 28 cycles later; valid=1, complete=1, count=0, first=0.
REQ-031 Same board with cell (0,0)=0 -> valid=1, complete=0, count=0.
REQ-032 Same board with (0,0)=5 (duplicate in row 0, col 0 and square 0) -> valid=0, count=3, first=0.
REQ-033 Same board with (0,0) and (0,1) swapped -> valid=0, count=2 (columns 0 and 1), first=9.
REQ-034 Same board with (8,8)=10 -> valid=0, first=8; then reset asserted mid-check on a second start -> busy=0 next cycle, no done pulse.
REQ-035 BOX_SIZE=2, all-zero board -> done 13 cycles after start; valid=1, complete=0, count=0; a start_in pulse while busy causes no second done.
